// File: rtl/data_fifo.sv
// Synchronous circular-buffer FIFO with registered read data, occupancy status
// and single-cycle pulses for rejected pushes and pops.
module data_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_nxt;

  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
  assign push_ok = wr_en && (!full || rd_en);
  assign pop_ok  = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wp] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + AW'(1);
      end
      if (pop_ok) begin
        data_out <= mem[rp];
        rp       <= rp + AW'(1);
      end
      data_valid <= pop_ok;
      overflow   <= wr_en && full && !rd_en;
      underflow  <= rd_en && empty;
      count      <= count_nxt;
      full       <= (count_nxt == CW'(DEPTH));
      empty      <= (count_nxt == '0);
    end
  end

endmodule

// File: doc/data_fifo.md
# data_fifo

Synchronous FIFO that sits directly downstream of the `asyc_reg` register stage and buffers its 8-bit `data_out` stream so a slower consumer can drain it under its own read enable. It uses a circular buffer with registered read data, full/empty/occupancy status, and one-cycle error pulses for rejected pushes and pops. Everything runs in a single clock domain.

## Interface

Parameters:
- `WIDTH`, 8, data width in bits; matches the register stage output.
- `DEPTH`, 8, number of entries; must be a power of two and at least 2.

Ports:
- `clk` in 1: the only clock; all sampling happens on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `data_in` in WIDTH: write data, driven from the register stage `data_out`.
- `wr_en` in 1: push request.
- `rd_en` in 1: pop request.
- `data_out` out WIDTH: registered read data.
- `data_valid` out 1: high for exactly one cycle when `data_out` carries a newly popped word.
- `full` out 1: count equals DEPTH.
- `empty` out 1: count equals 0.
- `count` out $clog2(DEPTH)+1: current occupancy, from 0 to DEPTH.
- `overflow` out 1: one-cycle pulse marking a rejected push.
- `underflow` out 1: one-cycle pulse marking a rejected pop.

## Operation

- Storage is a DEPTH×WIDTH array, with write pointer `wp` and read pointer `rp`.
  - Both pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked by a separate `count` register, not derived from pointer difference.
- Push accepted when `wr_en && (!full || rd_en)`:
  - `mem[wp] <= data_in`, then `wp` increments.
- Pop accepted when `rd_en && !empty`:
  - `data_out <= mem[rp]`, `rp` increments, and `data_valid <= 1`.
- Count update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or on neither.
- Simultaneous push and pop:
  - When full: both are accepted and count stays at DEPTH. The read uses the old `mem[rp]`; the write lands in the slot being freed.
  - When empty: the push is accepted and the pop is rejected. `underflow` pulses and count goes to 1. There is no fall-through of `data_in` to `data_out`.
- Rejections:
  - `overflow <= wr_en && full && !rd_en`.
  - `underflow <= rd_en && empty`.
  - A rejected operation changes no pointer, count or memory contents.
- `data_out` holds its last value whenever no pop is accepted. `data_valid` is 0 in those cycles.
- Reset, including reset asserted mid-stream, takes effect at the rising edge where `rst`=1:
  - `wp`, `rp`, `count`, `data_out`, `data_valid`, `overflow`, `underflow` all go to 0.
  - `empty`=1, `full`=0.
  - Memory contents are not cleared.
  - `wr_en` and `rd_en` are ignored in any cycle with `rst`=1.

## Timing

- All outputs are registered, with no combinational path from inputs to outputs.
  - `full`, `empty` and `count` reflect the state after the previous edge.
- Read latency: `rd_en` sampled high at edge N gives `data_out` and `data_valid` valid after edge N; the consumer samples them at edge N+1.
- Write-to-read: a word pushed at edge N can be popped at edge N+1 at the earliest, so it appears on `data_out` after edge N+1.
- Throughput is one push and one pop per cycle, sustained indefinitely when occupancy is between 1 and DEPTH-1.
- Flag pulses (`overflow`, `underflow`, `data_valid`) last exactly one cycle per offending or accepted request. Back-to-back requests give back-to-back pulses.
- `empty` deasserts on the edge after the first accepted push. `full` asserts on the edge where count reaches DEPTH.

## Test plan

- **Reset:** hold `rst`=1 for 2 cycles with `wr_en`=`rd_en`=1 → `count`=0, `empty`=1, `full`=0, `data_out`=0x00, all pulses 0.
- **Fill and drain:**
  - Push 0..7 on consecutive cycles → `full`=1 and `count`=8 after the 8th edge.
  - Pop 8 times → `data_out` sequence 0..7 with `data_valid` high each cycle, then `empty`=1.
- **Overflow:** while full, push 0xAA alone → `overflow` pulses once, `count` stays 8, and the next 8 pops return 0..7 (0xAA absent).
- **Underflow and empty simultaneous:**
  - Pop on empty → `underflow` pulses, `data_out` unchanged.
  - Push 0x55 together with pop on empty → `underflow`=1, `count`=1; next pop returns 0x55.
- **Wrap-around:** with `count` held at 4, run push and pop together for 20 cycles on data 0x10..0x23 → pops return 0x0C..0x1F in order and `count` stays 4.
- **Reset mid-operation:** at `count`=5, assert `rst` for 1 cycle → `count`=0 and `empty`=1 on the next edge. Then push 0x3C and pop it → `data_out`=0x3C.
